mux_carry_pipe: RTL



---
 rtl/mux_carry_pkg.sv | 37 +++
 rtl/mux_carry_stage.sv | 108 ++++++++++
 rtl/mux_carry_pipe.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mux_carry_pkg.sv
// Shared definitions for the pipelined select/carry lane datapath:
// operand bit positions, the per-lane result record and the lane function.
package mux_carry_pkg;

    // Bit positions inside the shared 4-bit operand word.
    localparam int D_H1 = 0;  // h source when sel=1
    localparam int D_H0 = 1;  // h source when sel=0
    localparam int D_G1 = 2;  // g source when sel=1
    localparam int D_G0 = 3;  // g source when sel=0

    typedef struct packed {
        logic s;       // sum bit of this lane
        logic c_out;   // carry into the next lane
        logic active;  // lane produced g or h
    } lane_out_t;

    // One lane: polarity picks the generate or the propagate-style term,
    // select picks which operand bit feeds it, then one ripple-carry step.
    function automatic lane_out_t lane_eval(
        input logic       sel,
        input logic       pol,
        input logic [3:0] d,
        input logic       c_in,
        input logic       kill
    );
        lane_out_t r;
        logic      g;
        logic      h;
        g        = pol & (sel ? d[D_G1] : d[D_G0]);
        h        = ~pol & (sel ? d[D_H1] : d[D_H0]);
        r.s      = g ^ h ^ c_in;
        r.c_out  = ~kill & (h | (g & c_in));
        r.active = g | h;
        return r;
    endfunction

endpackage

// File: rtl/mux_carry_stage.sv
// One pipeline stage: evaluates LANES_PER_STAGE lanes starting at BASE,
// folds them into the running sum/carry/none state and registers the
// result behind a valid bit with a ready chain (no skid buffer).
module mux_carry_stage
    import mux_carry_pkg::*;
#(
    parameter int LANES           = 4,
    parameter int LANES_PER_STAGE = 2,
    parameter int BASE            = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [3:0]       up_d,
    input  logic             up_kill,
    input  logic [LANES-1:0] up_sel,
    input  logic [LANES-1:0] up_pol,
    input  logic [LANES-1:0] up_sum,
    input  logic             up_carry,
    input  logic             up_none,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [3:0]       dn_d,
    output logic             dn_kill,
    output logic [LANES-1:0] dn_sel,
    output logic [LANES-1:0] dn_pol,
    output logic [LANES-1:0] dn_sum,
    output logic             dn_carry,
    output logic             dn_none,
    output logic             dn_all
);

    logic             advance_s;
    lane_out_t        lane_s;
    logic [LANES-1:0] sum_nxt_s;
    logic             carry_nxt_s;
    logic             none_nxt_s;
    logic             all_nxt_s;

    logic             valid_r;
    logic [3:0]       d_r;
    logic             kill_r;
    logic [LANES-1:0] sel_r;
    logic [LANES-1:0] pol_r;
    logic [LANES-1:0] sum_r;
    logic             carry_r;
    logic             none_r;
    logic             all_r;

    // The stage can take a new beat when empty or when its beat moves on.
    assign advance_s = ~valid_r | dn_ready;
    assign up_ready  = advance_s;

    // Ripple this stage's lanes onto the partial result handed in from upstream.
    always_comb begin
        sum_nxt_s   = up_sum;
        carry_nxt_s = up_carry;
        none_nxt_s  = up_none;
        lane_s      = lane_out_t'(3'b000);
        for (int i = 0; i < LANES_PER_STAGE; i++) begin
            lane_s               = lane_eval(up_sel[BASE+i], up_pol[BASE+i], up_d,
                                             carry_nxt_s, up_kill);
            sum_nxt_s[BASE+i]    = lane_s.s;
            carry_nxt_s          = lane_s.c_out;
            none_nxt_s           = none_nxt_s & ~lane_s.active;
        end
        all_nxt_s = &sum_nxt_s;
    end

    // Stage register: loads on advance, holds its beat while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            d_r     <= 4'b0000;
            kill_r  <= 1'b0;
            sel_r   <= {LANES{1'b0}};
            pol_r   <= {LANES{1'b0}};
            sum_r   <= {LANES{1'b0}};
            carry_r <= 1'b0;
            none_r  <= 1'b0;
            all_r   <= 1'b0;
        end else if (advance_s) begin
            valid_r <= up_valid;
            if (up_valid) begin
                d_r     <= up_d;
                kill_r  <= up_kill;
                sel_r   <= up_sel;
                pol_r   <= up_pol;
                sum_r   <= sum_nxt_s;
                carry_r <= carry_nxt_s;
                none_r  <= none_nxt_s;
                all_r   <= all_nxt_s;
            end
        end
    end

    assign dn_valid = valid_r;
    assign dn_d     = d_r;
    assign dn_kill  = kill_r;
    assign dn_sel   = sel_r;
    assign dn_pol   = pol_r;
    assign dn_sum   = sum_r;
    assign dn_carry = carry_r;
    assign dn_none  = none_r;
    assign dn_all   = all_r;

endmodule

// File: rtl/mux_carry_pipe.sv
// Pipelined select/carry lane block: NSTAGE chained stages with a
// valid/ready handshake, registered result flags and a saturating
// counter of accepted all-ones results.
module mux_carry_pipe
    import mux_carry_pkg::*;
#(
    parameter int LANES           = 4,
    parameter int LANES_PER_STAGE = 2,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_d,
    input  logic [LANES-1:0] in_sel,
    input  logic [LANES-1:0] in_pol,
    input  logic             in_kill,
    input  logic             in_seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] out_sum,
    output logic             out_all,
    output logic             out_none,
    output logic             out_cout,
    output logic [CNT_W-1:0] hit_cnt,
    input  logic             cnt_clr
);

    localparam int NSTAGE = (LANES_PER_STAGE > 0) ? (LANES / LANES_PER_STAGE) : 1;

    generate
        if (LANES < 1 || LANES_PER_STAGE < 1 || (LANES % LANES_PER_STAGE) != 0) begin : g_bad_cfg
            $error("mux_carry_pipe: LANES_PER_STAGE must be >=1 and divide LANES");
        end
    endgenerate

    // Index k is the input of stage k; index NSTAGE is the last stage output.
    logic [NSTAGE:0]            valid_s;
    logic [NSTAGE:0]            ready_s;
    logic [NSTAGE:0][3:0]       d_s;
    logic [NSTAGE:0]            kill_s;
    logic [NSTAGE:0][LANES-1:0] sel_s;
    logic [NSTAGE:0][LANES-1:0] pol_s;
    logic [NSTAGE:0][LANES-1:0] sum_s;
    logic [NSTAGE:0]            carry_s;
    logic [NSTAGE:0]            none_s;
    logic [NSTAGE-1:0]          all_s;
    logic                       out_xfer_s;
    logic                       unused_s;

    logic [CNT_W-1:0]           hit_cnt_r;

    // Pipeline entry: empty sum, seeded carry (killed beats start at 0).
    assign valid_s[0]      = in_valid;
    assign d_s[0]          = in_d;
    assign kill_s[0]       = in_kill;
    assign sel_s[0]        = in_sel;
    assign pol_s[0]        = in_pol;
    assign sum_s[0]        = {LANES{1'b0}};
    assign carry_s[0]      = in_seed & ~in_kill;
    assign none_s[0]       = 1'b1;
    assign ready_s[NSTAGE] = out_ready;
    assign in_ready        = ready_s[0];

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        mux_carry_stage #(
            .LANES           (LANES),
            .LANES_PER_STAGE (LANES_PER_STAGE),
            .BASE            (k * LANES_PER_STAGE)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (valid_s[k]),
            .up_ready (ready_s[k]),
            .up_d     (d_s[k]),
            .up_kill  (kill_s[k]),
            .up_sel   (sel_s[k]),
            .up_pol   (pol_s[k]),
            .up_sum   (sum_s[k]),
            .up_carry (carry_s[k]),
            .up_none  (none_s[k]),
            .dn_valid (valid_s[k+1]),
            .dn_ready (ready_s[k+1]),
            .dn_d     (d_s[k+1]),
            .dn_kill  (kill_s[k+1]),
            .dn_sel   (sel_s[k+1]),
            .dn_pol   (pol_s[k+1]),
            .dn_sum   (sum_s[k+1]),
            .dn_carry (carry_s[k+1]),
            .dn_none  (none_s[k+1]),
            .dn_all   (all_s[k])
        );
    end

    // Results come straight from the last stage registers.
    assign out_valid  = valid_s[NSTAGE];
    assign out_sum    = sum_s[NSTAGE];
    assign out_cout   = carry_s[NSTAGE];
    assign out_none   = none_s[NSTAGE];
    assign out_all    = all_s[NSTAGE-1];
    assign out_xfer_s = out_valid & out_ready;

    // Operand context leaving the last stage and intermediate all flags have no consumer.
    assign unused_s = &{1'b0, d_s[NSTAGE], kill_s[NSTAGE], sel_s[NSTAGE], pol_s[NSTAGE], all_s};

    // Saturating count of delivered all-ones results; clear wins over a same-cycle hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            hit_cnt_r <= {CNT_W{1'b0}};
        end else if (out_xfer_s && out_all && (hit_cnt_r != {CNT_W{1'b1}})) begin
            hit_cnt_r <= hit_cnt_r + CNT_W'(1'b1);
        end
    end

    assign hit_cnt = hit_cnt_r;

endmodule
